// File: rtl/axis_write_data_pkg.sv
// Shared types and helpers for the write-side stream-to-AXI packer.
package axis_write_data_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Ceiling log2, never below 1 so counters derived from it are never zero-width.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/axis_write_data_if.sv
// Config, narrow input stream and AXI W channel signals of the write data path.
interface axis_write_data_if #(
  parameter int CFG_DWIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_DATA_WIDTH = 256
);
  logic [CFG_DWIDTH-1:0]       cfg_length;
  logic                        cfg_val;
  logic                        cfg_rdy;
  logic [DATA_WIDTH-1:0]       data;
  logic                        valid;
  logic                        ready;
  logic [AXI_DATA_WIDTH-1:0]   axi_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb;
  logic                        axi_wlast;
  logic                        axi_wvalid;
  logic                        axi_wready;

  // Packer side
  modport slave (
    input  cfg_length, cfg_val, data, valid, axi_wready,
    output cfg_rdy, ready, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid
  );

  // User / AXI master side
  modport master (
    output cfg_length, cfg_val, data, valid, axi_wready,
    input  cfg_rdy, ready, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid
  );
endinterface

// File: rtl/axis_write_buf.sv
// Synchronous first-word-fall-through FIFO holding packed beats {wlast, wstrb, wdata}.
module axis_write_buf #(
  parameter int AWIDTH = 4,
  parameter int WIDTH  = 289
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);
  localparam int                DEPTH    = 1 << AWIDTH;
  localparam logic [AWIDTH:0]   FULL_CNT = (AWIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [AWIDTH:0]   r_count;
  logic              w_push;
  logic              w_pop;

  // A full FIFO still accepts a push on the same edge a beat leaves.
  assign o_valid = (r_count != '0);
  assign w_pop   = o_valid & i_ready;
  assign o_ready = (r_count != FULL_CNT) | w_pop;
  assign w_push  = i_valid & o_ready;
  // Idle output reads as zero rather than stale storage.
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

  // Storage write; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy tracking; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AWIDTH'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AWIDTH'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AWIDTH+1)'(1);
        2'b01:   r_count <= r_count - (AWIDTH+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/axis_write_data.sv
// Packs WIDTH_RATIO narrow stream words per AXI W beat, with strobes and per-burst wlast.
module axis_write_data
  import axis_write_data_pkg::*;
#(
  parameter int BUF_AWIDTH     = 4,
  parameter int CFG_DWIDTH     = 32,
  parameter int WIDTH_RATIO    = 8,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int DATA_WIDTH     = 32,
  parameter int BURST_LENGTH   = 16
) (
  input logic              clk,
  input logic              rst,
  axis_write_data_if.slave bus
);
  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int LANE_BYTES = DATA_WIDTH / 8;
  localparam int LANE_W     = clog2(WIDTH_RATIO);
  localparam int BURST_W    = clog2(BURST_LENGTH);
  localparam int BUF_WIDTH  = AXI_DATA_WIDTH + STRB_WIDTH + 1;
  localparam logic [LANE_W-1:0]  LAST_LANE     = LANE_W'(WIDTH_RATIO - 1);
  localparam logic [BURST_W-1:0] LAST_IN_BURST = BURST_W'(BURST_LENGTH - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [LANE_W-1:0]         r_lane;
  logic [CFG_DWIDTH-1:0]     r_words_left;
  logic [CFG_DWIDTH:0]       r_beats_left;
  logic [BURST_W-1:0]        r_burst_cnt;
  logic [AXI_DATA_WIDTH-1:0] r_lanes;
  logic [STRB_WIDTH-1:0]     r_strb;
  logic [AXI_DATA_WIDTH-1:0] w_beat_data;
  logic [STRB_WIDTH-1:0]     w_beat_strb;
  logic [CFG_DWIDTH:0]       w_beats;
  logic                      w_cfg_take;
  logic                      w_last_word;
  logic                      w_ready;
  logic                      w_cfg_rdy;
  logic                      w_accept;
  logic                      w_push;
  logic                      w_wlast;
  logic                      w_buf_in_rdy;
  logic                      w_buf_vld;
  logic                      w_hs;
  logic [BUF_WIDTH-1:0]      w_buf_out;

  assign w_cfg_take  = (r_state == ST_IDLE) & bus.cfg_val & (bus.cfg_length != '0);
  assign w_beats     = ({1'b0, bus.cfg_length} + (CFG_DWIDTH+1)'(WIDTH_RATIO - 1)) >> LANE_W;
  assign w_last_word = (r_words_left == CFG_DWIDTH'(1));
  assign w_accept    = bus.valid & w_ready;
  assign w_push      = w_accept & ((r_lane == LAST_LANE) | w_last_word);
  // wlast is decided at push time; beats leave in push order, so the
  // push-side burst position equals the handshake position at the output.
  assign w_wlast     = (r_burst_cnt == LAST_IN_BURST) | w_last_word;
  assign w_hs        = w_buf_vld & bus.axi_wready;

  // Merge the incoming word into its lane; lanes start cleared so untouched ones stay zero.
  always_comb begin
    w_beat_data = r_lanes;
    w_beat_strb = r_strb;
    w_beat_data[r_lane*DATA_WIDTH +: DATA_WIDTH] = bus.data;
    w_beat_strb[r_lane*LANE_BYTES +: LANE_BYTES] = '1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cfg_rdy   = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cfg_rdy = 1'b1;
        if (w_cfg_take) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // Any word that completes a beat needs FIFO room; others only fill a lane.
        w_ready = w_buf_in_rdy | ((r_lane != LAST_LANE) & ~w_last_word);
        if (bus.valid & w_ready & w_last_word) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_beats_left == '0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Lane, word, burst and outstanding-beat counters, all restarted by a new config.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane       <= '0;
      r_words_left <= '0;
      r_beats_left <= '0;
      r_burst_cnt  <= '0;
    end else if (w_cfg_take) begin
      r_lane       <= '0;
      r_words_left <= bus.cfg_length;
      r_beats_left <= w_beats;
      r_burst_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_words_left <= r_words_left - CFG_DWIDTH'(1);
        r_lane       <= w_push ? '0 : r_lane + LANE_W'(1);
      end
      if (w_push)
        r_burst_cnt <= (r_burst_cnt == LAST_IN_BURST) ? '0 : r_burst_cnt + BURST_W'(1);
      if (w_hs)
        r_beats_left <= r_beats_left - (CFG_DWIDTH+1)'(1);
    end
  end

  // Lane accumulator; cleared on config so lanes left over from an aborted transfer vanish.
  always_ff @(posedge clk) begin
    if (w_cfg_take | w_push) begin
      r_lanes <= '0;
      r_strb  <= '0;
    end else if (w_accept) begin
      r_lanes <= w_beat_data;
      r_strb  <= w_beat_strb;
    end
  end

  axis_write_buf #(
    .AWIDTH (BUF_AWIDTH),
    .WIDTH  (BUF_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_data  ({w_wlast, w_beat_strb, w_beat_data}),
    .i_valid (w_push),
    .o_ready (w_buf_in_rdy),
    .o_data  (w_buf_out),
    .o_valid (w_buf_vld),
    .i_ready (bus.axi_wready)
  );

  assign bus.cfg_rdy    = w_cfg_rdy;
  assign bus.ready      = w_ready;
  assign bus.axi_wvalid = w_buf_vld;
  assign bus.axi_wdata  = w_buf_out[AXI_DATA_WIDTH-1:0];
  assign bus.axi_wstrb  = w_buf_out[AXI_DATA_WIDTH +: STRB_WIDTH];
  assign bus.axi_wlast  = w_buf_out[BUF_WIDTH-1];
endmodule

// File: tb/tb_axis_write_data.sv
// Directed bench for axis_write_data: packing, strobes, wlast, backpressure, reset, config rules.
module tb_axis_write_data;
  localparam int DW = 32;
  localparam int AW = 256;
  localparam int WR = 8;
  localparam int CW = 32;
  localparam int BL = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [AW-1:0]   cap_data [$];
  logic [AW/8-1:0] cap_strb [$];
  logic            cap_last [$];

  axis_write_data_if #(.CFG_DWIDTH(CW), .DATA_WIDTH(DW), .AXI_DATA_WIDTH(AW)) bus ();

  axis_write_data #(
    .BUF_AWIDTH(4), .CFG_DWIDTH(CW), .WIDTH_RATIO(WR),
    .AXI_DATA_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LENGTH(BL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every W handshake that the coming rising edge will perform.
  always @(negedge clk) begin
    #2;
    if (!rst && bus.axi_wvalid && bus.axi_wready) begin
      cap_data.push_back(bus.axi_wdata);
      cap_strb.push_back(bus.axi_wstrb);
      cap_last.push_back(bus.axi_wlast);
    end
  end

  task automatic clear_caps();
    cap_data.delete();
    cap_strb.delete();
    cap_last.delete();
  endtask

  // Called at a falling edge; config is taken at the next rising edge.
  task automatic do_cfg(input int len);
    bus.cfg_length = CW'(len);
    bus.cfg_val    = 1'b1;
    @(negedge clk);
    bus.cfg_val    = 1'b0;
  endtask

  // Feed words base+first..base+len-1 until the block is back in IDLE.
  task automatic stream(input int len, input int base, input int first, input bit rnd_v,
                        input bit rnd_w, input int pulse_at, input int budget, output bit done);
    int sent;
    int n;
    sent = first;
    n    = 0;
    done = 1'b0;
    while (n < budget) begin
      if (sent >= len && bus.cfg_rdy) begin
        done = 1'b1;
        break;
      end
      bus.valid      = (sent < len) && (!rnd_v || $urandom_range(0, 1) == 1);
      bus.data       = DW'(base + sent);
      bus.axi_wready = !rnd_w || ($urandom_range(0, 3) != 0);
      bus.cfg_val    = (n == pulse_at);
      bus.cfg_length = CW'(3);
      #1;
      if (bus.valid && bus.ready) sent++;
      @(negedge clk);
      n++;
    end
    bus.valid   = 1'b0;
    bus.cfg_val = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.cfg_rdy !== 1'b1) begin bad++; $display("FAIL rst_cfg_rdy got=%b exp=1", bus.cfg_rdy); end
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", bus.ready); end
    total++; if (bus.axi_wvalid !== 1'b0) begin bad++; $display("FAIL rst_wvalid got=%b exp=0", bus.axi_wvalid); end
    total++; if (bus.axi_wlast !== 1'b0) begin bad++; $display("FAIL rst_wlast got=%b exp=0", bus.axi_wlast); end
    total++; if (bus.axi_wdata !== '0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", bus.axi_wdata); end
    total++; if (bus.axi_wstrb !== '0) begin bad++; $display("FAIL rst_wstrb got=%h exp=0", bus.axi_wstrb); end
    @(negedge clk);
  endtask

  task automatic test_partial();
    bit done;
    clear_caps();
    do_cfg(10);
    stream(10, 1, 0, 1'b0, 1'b0, -1, 200, done);
    total++; if (!done) begin bad++; $display("FAIL partial_timeout got=0 exp=1"); end
    total++;
    if (cap_data.size() != 2) begin
      bad++; $display("FAIL partial_beats got=%0d exp=2", cap_data.size());
    end else begin
      total++; if (cap_data[0] !== 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001)
        begin bad++; $display("FAIL partial_data0 got=%h", cap_data[0]); end
      total++; if (cap_strb[0] !== 32'hFFFFFFFF) begin bad++; $display("FAIL partial_strb0 got=%h exp=ffffffff", cap_strb[0]); end
      total++; if (cap_last[0] !== 1'b0) begin bad++; $display("FAIL partial_last0 got=%b exp=0", cap_last[0]); end
      total++; if (cap_data[1] !== 256'h0000000a_00000009)
        begin bad++; $display("FAIL partial_data1 got=%h", cap_data[1]); end
      total++; if (cap_strb[1] !== 32'h000000FF) begin bad++; $display("FAIL partial_strb1 got=%h exp=000000ff", cap_strb[1]); end
      total++; if (cap_last[1] !== 1'b1) begin bad++; $display("FAIL partial_last1 got=%b exp=1", cap_last[1]); end
    end
    total++; if (bus.cfg_rdy !== 1'b1) begin bad++; $display("FAIL partial_cfg_rdy got=%b exp=1", bus.cfg_rdy); end
  endtask

  task automatic test_bursts();
    bit done;
    clear_caps();
    do_cfg(256);
    stream(256, 1, 0, 1'b0, 1'b0, -1, 1000, done);
    total++; if (!done) begin bad++; $display("FAIL bursts_timeout got=0 exp=1"); end
    total++;
    if (cap_data.size() != 32) begin
      bad++; $display("FAIL bursts_beats got=%0d exp=32", cap_data.size());
    end else begin
      for (int k = 0; k < 32; k++) begin
        total++;
        if (cap_last[k] !== (k == 15 || k == 31) || cap_data[k][31:0] !== DW'(k*8 + 1) ||
            cap_strb[k] !== 32'hFFFFFFFF) begin
          bad++;
          $display("FAIL bursts_beat%0d got last=%b w0=%h strb=%h exp last=%b w0=%h strb=ffffffff",
                   k, cap_last[k], cap_data[k][31:0], cap_strb[k], (k == 15 || k == 31), k*8 + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit done;
    int sent;
    logic [AW-1:0] held;
    clear_caps();
    do_cfg(200);
    sent = 0;
    held = '0;
    for (int n = 0; n < 150; n++) begin
      bus.valid      = 1'b1;
      bus.data       = DW'(1 + sent);
      bus.axi_wready = 1'b0;
      #1;
      if (bus.ready) sent++;
      if (n == 20) held = bus.axi_wdata;
      @(negedge clk);
    end
    bus.valid = 1'b0;
    #1;
    total++; if (sent != 135) begin bad++; $display("FAIL bp_accepted got=%0d exp=135", sent); end
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", bus.ready); end
    total++; if (bus.axi_wvalid !== 1'b1) begin bad++; $display("FAIL bp_wvalid got=%b exp=1", bus.axi_wvalid); end
    total++; if (bus.axi_wdata !== held || held[31:0] !== 32'd1)
      begin bad++; $display("FAIL bp_hold got=%h held=%h exp_w0=1", bus.axi_wdata, held); end
    @(negedge clk);
    stream(200, 1, sent, 1'b0, 1'b0, -1, 1000, done);
    total++; if (!done) begin bad++; $display("FAIL bp_timeout got=0 exp=1"); end
    total++;
    if (cap_data.size() != 25) begin
      bad++; $display("FAIL bp_beats got=%0d exp=25", cap_data.size());
    end else begin
      for (int k = 0; k < 25; k++) begin
        int err;
        err = 0;
        for (int j = 0; j < WR; j++)
          if (cap_data[k][j*DW +: DW] !== DW'(k*8 + j + 1)) err++;
        total++;
        if (err != 0 || cap_last[k] !== (k == 15 || k == 24) || cap_strb[k] !== 32'hFFFFFFFF) begin
          bad++;
          $display("FAIL bp_beat%0d got lane_errs=%0d last=%b strb=%h exp lane_errs=0 last=%b",
                   k, err, cap_last[k], cap_strb[k], (k == 15 || k == 24));
        end
      end
    end
  endtask

  task automatic test_cfg_ignore();
    bit done;
    clear_caps();
    bus.cfg_length = '0;
    bus.cfg_val    = 1'b1;
    bus.valid      = 1'b1;
    bus.axi_wready = 1'b1;
    @(negedge clk);
    bus.cfg_val = 1'b0;
    #1;
    total++; if (bus.cfg_rdy !== 1'b1) begin bad++; $display("FAIL zero_cfg_rdy got=%b exp=1", bus.cfg_rdy); end
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL zero_ready got=%b exp=0", bus.ready); end
    repeat (3) @(negedge clk);
    bus.valid = 1'b0;
    total++; if (cap_data.size() != 0 || bus.axi_wvalid !== 1'b0)
      begin bad++; $display("FAIL zero_beats got=%0d wvalid=%b exp=0 0", cap_data.size(), bus.axi_wvalid); end
    do_cfg(16);
    stream(16, 1, 0, 1'b0, 1'b0, 4, 200, done);
    total++; if (!done) begin bad++; $display("FAIL ign_timeout got=0 exp=1"); end
    total++;
    if (cap_data.size() != 2) begin
      bad++; $display("FAIL ign_beats got=%0d exp=2", cap_data.size());
    end else begin
      total++; if (cap_data[0][31:0] !== 32'd1 || cap_data[1][255:224] !== 32'd16)
        begin bad++; $display("FAIL ign_data got=%h/%h exp=1/10", cap_data[0][31:0], cap_data[1][255:224]); end
      total++; if (cap_last[0] !== 1'b0 || cap_last[1] !== 1'b1)
        begin bad++; $display("FAIL ign_last got=%b%b exp=01", cap_last[0], cap_last[1]); end
    end
  endtask

  task automatic test_reset_mid();
    bit done;
    clear_caps();
    do_cfg(20);
    for (int n = 0; n < 12; n++) begin
      bus.valid      = 1'b1;
      bus.data       = DW'(100 + n);
      bus.axi_wready = 1'b0;
      @(negedge clk);
    end
    bus.valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.axi_wvalid !== 1'b0) begin bad++; $display("FAIL rmid_wvalid got=%b exp=0", bus.axi_wvalid); end
    total++; if (bus.cfg_rdy !== 1'b1) begin bad++; $display("FAIL rmid_cfg_rdy got=%b exp=1", bus.cfg_rdy); end
    @(negedge clk);
    do_cfg(8);
    stream(8, 1, 0, 1'b0, 1'b0, -1, 200, done);
    total++; if (!done) begin bad++; $display("FAIL rmid_timeout got=0 exp=1"); end
    total++;
    if (cap_data.size() != 1) begin
      bad++; $display("FAIL rmid_beats got=%0d exp=1", cap_data.size());
    end else begin
      total++;
      if (cap_data[0] !== 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001 ||
          cap_strb[0] !== 32'hFFFFFFFF || cap_last[0] !== 1'b1) begin
        bad++; $display("FAIL rmid_beat got=%h strb=%h last=%b", cap_data[0], cap_strb[0], cap_last[0]);
      end
    end
  endtask

  task automatic test_random();
    bit done;
    clear_caps();
    do_cfg(1000);
    stream(1000, 32'h1000, 0, 1'b1, 1'b1, -1, 20000, done);
    total++; if (!done) begin bad++; $display("FAIL rand_timeout got=0 exp=1"); end
    total++;
    if (cap_data.size() != 125) begin
      bad++; $display("FAIL rand_beats got=%0d exp=125", cap_data.size());
    end else begin
      for (int k = 0; k < 125; k++) begin
        int err;
        bit exp_last;
        err = 0;
        exp_last = (k % 16 == 15) || (k == 124);
        for (int j = 0; j < WR; j++)
          if (cap_data[k][j*DW +: DW] !== DW'(32'h1000 + k*8 + j)) err++;
        total++;
        if (err != 0 || cap_last[k] !== exp_last || cap_strb[k] !== 32'hFFFFFFFF) begin
          bad++;
          $display("FAIL rand_beat%0d got lane_errs=%0d last=%b strb=%h exp lane_errs=0 last=%b",
                   k, err, cap_last[k], cap_strb[k], exp_last);
        end
      end
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    bus.cfg_length = '0;
    bus.cfg_val    = 1'b0;
    bus.data       = '0;
    bus.valid      = 1'b0;
    bus.axi_wready = 1'b0;
    @(negedge clk);
    test_reset();
    test_partial();
    test_bursts();
    test_backpressure();
    test_cfg_ignore();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
